// File: rtl/fb_rect_fill.sv
// -----------------------------------------------------------------------------
// fb_rect_fill
//
// Fills an axis-aligned rectangle of a framebuffer with a single colour.
// A command gives the top-left corner, the size and the colour. The block
// clips the rectangle against the framebuffer edges. It then issues one
// framebuffer write per cycle in row-major order.
//
// Handshake: a command transfers on a rising edge of `clock` where both
// `cmd_valid` and `cmd_ready` are high. `cmd_ready` is high only while the
// block is idle, so a command presented while busy is simply not taken.
// Its fields are never captured in that case.
//
// Ports:
//   clock, reset_n        clock; asynchronous active-low reset
//   cmd_valid, cmd_ready  command handshake
//   cmd_x, cmd_y          rectangle top-left corner (pixels)
//   cmd_w, cmd_h          rectangle width/height (pixels)
//   cmd_color             fill value, {R,G,B} 4 bits each by default
//   abort                 cancel a fill in CLIP/FILL, no done pulse
//   fb_address, fb_data   registered framebuffer write port
//   fb_wren               registered write enable
//   busy                  high whenever the block is not idle
//   done                  one-cycle pulse on normal completion
//   state_dbg             current FSM state (IDLE=0, CLIP=1, FILL=2, DONE=3)
// -----------------------------------------------------------------------------
module fb_rect_fill #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [7:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    input  logic              abort,
    output logic [ADDR_W-1:0] fb_address,
    output logic [DATA_W-1:0] fb_data,
    output logic              fb_wren,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLIP = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [8:0]        FB_W9    = 9'(FB_W);
    localparam logic [8:0]        FB_H9    = 9'(FB_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

    state_t            state;
    logic [7:0]        cap_x;
    logic [7:0]        cap_y;
    logic [7:0]        cap_w;
    logic [7:0]        cap_h;
    logic [8:0]        cur_x;
    logic [8:0]        cur_y;
    logic [ADDR_W-1:0] row_base;   // cur_y * FB_W, stepped by FB_W per row

    // Clipped exclusive end coordinates. The 9-bit sums cannot wrap:
    // 255 + 255 = 510 fits in 9 bits.
    logic [8:0] x_sum;
    logic [8:0] y_sum;
    logic [8:0] x_end;
    logic [8:0] y_end;
    logic       empty_rect;
    logic       x_last;
    logic       y_last;
    logic [ADDR_W-1:0] first_row_base;
    logic [ADDR_W-1:0] next_row_base;

    always_comb begin
        x_sum          = {1'b0, cap_x} + {1'b0, cap_w};
        y_sum          = {1'b0, cap_y} + {1'b0, cap_h};
        x_end          = (x_sum > FB_W9) ? FB_W9 : x_sum;
        y_end          = (y_sum > FB_H9) ? FB_H9 : y_sum;
        // A corner outside the framebuffer leaves nothing to draw. A zero
        // size leaves nothing to draw either.
        empty_rect     = (cap_w == 8'd0) || (cap_h == 8'd0) ||
                         ({1'b0, cap_x} >= FB_W9) || ({1'b0, cap_y} >= FB_H9);
        x_last         = ((cur_x + 9'd1) == x_end);
        y_last         = ((cur_y + 9'd1) == y_end);
        first_row_base = ADDR_W'(cap_y) * ROW_STEP;
        next_row_base  = row_base + ROW_STEP;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cap_x      <= '0;
            cap_y      <= '0;
            cap_w      <= '0;
            cap_h      <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            row_base   <= '0;
            fb_address <= '0;
            fb_data    <= '0;
            fb_wren    <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    fb_wren <= 1'b0;
                    done    <= 1'b0;
                    // abort has no meaning here; a command still transfers.
                    if (cmd_valid) begin
                        cap_x   <= cmd_x;
                        cap_y   <= cmd_y;
                        cap_w   <= cmd_w;
                        cap_h   <= cmd_h;
                        fb_data <= cmd_color;
                        state   <= ST_CLIP;
                    end
                end

                ST_CLIP: begin
                    if (abort) begin
                        fb_wren <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (empty_rect) begin
                        fb_wren <= 1'b0;
                        done    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        // First pixel is presented on this edge. This gives a
                        // write in the second cycle after acceptance.
                        cur_x      <= {1'b0, cap_x};
                        cur_y      <= {1'b0, cap_y};
                        row_base   <= first_row_base;
                        fb_address <= first_row_base + ADDR_W'(cap_x);
                        fb_wren    <= 1'b1;
                        state      <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    if (abort) begin
                        fb_wren <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (!x_last) begin
                        cur_x      <= cur_x + 9'd1;
                        fb_address <= fb_address + 1'b1;
                    end else if (!y_last) begin
                        cur_x      <= {1'b0, cap_x};
                        cur_y      <= cur_y + 9'd1;
                        row_base   <= next_row_base;
                        fb_address <= next_row_base + ADDR_W'(cap_x);
                    end else begin
                        fb_wren <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    fb_wren <= 1'b0;
                    done    <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: begin
                    fb_wren <= 1'b0;
                    done    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register, so reset forces them at once.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_fb_rect_fill.sv
module tb_fb_rect_fill;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [11:0] cmd_color;
  logic        abort;
  logic [14:0] fb_address;
  logic [11:0] fb_data;
  logic        fb_wren;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;

  logic [14:0] exp_q[$];
  logic [14:0] wr_q[$];
  logic [11:0] dat_q[$];

  // results of the last collect run
  int r_n, r_first, r_last, r_done_cnt, r_done_cyc, r_ready_cyc, r_busy_bad;
  bit r_timeout;

  fb_rect_fill dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .abort(abort),
    .fb_address(fb_address), .fb_data(fb_data), .fb_wren(fb_wren),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] w, input logic [7:0] h,
                          input logic [11:0] color);
    @(negedge clock);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = color;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Samples on falling edges after acceptance. Cycle 1 is the first cycle
  // after the accepting edge. Stops at the first cycle cmd_ready is seen high.
  task automatic collect(input int max_cyc, input int abort_after);
    bit aborted;
    aborted = 1'b0;
    r_n = 0; r_first = -1; r_last = -1; r_done_cnt = 0; r_done_cyc = -1;
    r_ready_cyc = -1; r_busy_bad = 0; r_timeout = 1'b1;
    wr_q.delete(); dat_q.delete();
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clock);
      if (abort) abort = 1'b0;
      if (fb_wren) begin
        r_n++;
        wr_q.push_back(fb_address);
        dat_q.push_back(fb_data);
        if (r_first < 0) r_first = c;
        r_last = c;
      end
      if (done) begin r_done_cnt++; r_done_cyc = c; end
      if (busy === cmd_ready) r_busy_bad++;
      if (cmd_ready) begin r_ready_cyc = c; r_timeout = 1'b0; break; end
      if (abort_after > 0 && r_n == abort_after && !aborted) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
    end
    abort = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_x = 8'd0; cmd_y = 8'd0; cmd_w = 8'd0; cmd_h = 8'd0; cmd_color = 12'h0;
    #2;
    total++; if (fb_wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", fb_wren); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (fb_address !== 15'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", fb_address); end
    total++; if (fb_data !== 12'd0) begin bad++; $display("FAIL reset_data: got %h want 000", fb_data); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_basic;
    int dbad;
    send_cmd(8'd2, 8'd3, 8'd3, 8'd2, 12'hF00);
    collect(100, 0);
    exp_q = '{15'd482, 15'd483, 15'd484, 15'd642, 15'd643, 15'd644};
    total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", r_timeout); end
    total++; if (r_n !== 6) begin bad++; $display("FAIL basic_count: got %0d want 6", r_n); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, wr_q[i], exp_q[i]); end
    end
    dbad = 0;
    foreach (dat_q[i]) if (dat_q[i] !== 12'hF00) dbad++;
    total++; if (dbad !== 0) begin bad++; $display("FAIL basic_data: got %0d wrong words want 0", dbad); end
    total++; if (r_first !== 2) begin bad++; $display("FAIL basic_first: got cycle %0d want 2", r_first); end
    total++; if (r_last !== 7) begin bad++; $display("FAIL basic_last: got cycle %0d want 7", r_last); end
    total++; if (r_done_cnt !== 1 || r_done_cyc !== 8) begin bad++; $display("FAIL basic_done: got cnt %0d cyc %0d want 1 at 8", r_done_cnt, r_done_cyc); end
    total++; if (r_ready_cyc !== 9) begin bad++; $display("FAIL basic_ready: got cycle %0d want 9", r_ready_cyc); end
    total++; if (r_busy_bad !== 0) begin bad++; $display("FAIL basic_busy: got %0d bad cycles want 0", r_busy_bad); end
  endtask

  task automatic test_clip;
    send_cmd(8'd158, 8'd119, 8'd10, 8'd10, 12'h0F0);
    collect(100, 0);
    exp_q = '{15'd19198, 15'd19199};
    total++; if (r_n !== 2) begin bad++; $display("FAIL clip_count: got %0d want 2", r_n); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL clip_addr[%0d]: got %0d want %0d", i, wr_q[i], exp_q[i]); end
    end
    total++; if (r_done_cnt !== 1 || r_done_cyc !== 4) begin bad++; $display("FAIL clip_done: got cnt %0d cyc %0d want 1 at 4", r_done_cnt, r_done_cyc); end
  endtask

  task automatic test_empty;
    send_cmd(8'd5, 8'd5, 8'd0, 8'd4, 12'h123);
    collect(20, 0);
    total++; if (r_n !== 0) begin bad++; $display("FAIL empty_w0_count: got %0d want 0", r_n); end
    total++; if (r_done_cnt !== 1 || r_done_cyc !== 2) begin bad++; $display("FAIL empty_w0_done: got cnt %0d cyc %0d want 1 at 2", r_done_cnt, r_done_cyc); end
    total++; if (r_ready_cyc !== 3) begin bad++; $display("FAIL empty_w0_ready: got cycle %0d want 3", r_ready_cyc); end
    send_cmd(8'd200, 8'd0, 8'd5, 8'd5, 12'h456);
    collect(20, 0);
    total++; if (r_n !== 0) begin bad++; $display("FAIL empty_x200_count: got %0d want 0", r_n); end
    total++; if (r_done_cnt !== 1 || r_done_cyc !== 2) begin bad++; $display("FAIL empty_x200_done: got cnt %0d cyc %0d want 1 at 2", r_done_cnt, r_done_cyc); end
    total++; if (r_ready_cyc !== 3) begin bad++; $display("FAIL empty_x200_ready: got cycle %0d want 3", r_ready_cyc); end
  endtask

  task automatic test_full;
    int first_bad;
    send_cmd(8'd0, 8'd0, 8'd160, 8'd120, 12'h00F);
    collect(19300, 0);
    total++; if (r_n !== 19200) begin bad++; $display("FAIL full_count: got %0d want 19200", r_n); end
    first_bad = -1;
    foreach (wr_q[i]) if (first_bad < 0 && wr_q[i] !== 15'(i)) first_bad = i;
    total++; if (first_bad !== -1) begin bad++; $display("FAIL full_addr: got first wrong index %0d want none", first_bad); end
    total++; if (r_first !== 2 || r_last !== 19201) begin bad++; $display("FAIL full_span: got %0d..%0d want 2..19201", r_first, r_last); end
    total++; if (r_busy_bad !== 0) begin bad++; $display("FAIL full_busy: got %0d bad cycles want 0", r_busy_bad); end
    total++; if (r_done_cnt !== 1 || r_done_cyc !== 19202) begin bad++; $display("FAIL full_done: got cnt %0d cyc %0d want 1 at 19202", r_done_cnt, r_done_cyc); end
  endtask

  task automatic test_abort;
    send_cmd(8'd10, 8'd10, 8'd4, 8'd4, 12'hABC);
    collect(100, 5);
    exp_q = '{15'd1610, 15'd1611, 15'd1612, 15'd1613, 15'd1770};
    total++; if (r_n !== 5) begin bad++; $display("FAIL abort_count: got %0d want 5", r_n); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_addr[%0d]: got %0d want %0d", i, wr_q[i], exp_q[i]); end
    end
    total++; if (r_done_cnt !== 0) begin bad++; $display("FAIL abort_nodone: got %0d pulses want 0", r_done_cnt); end
    total++; if (r_ready_cyc !== 7) begin bad++; $display("FAIL abort_idle: got ready cycle %0d want 7", r_ready_cyc); end
    send_cmd(8'd1, 8'd1, 8'd1, 8'd2, 12'h123);
    collect(100, 0);
    exp_q = '{15'd161, 15'd321};
    total++; if (r_n !== 2) begin bad++; $display("FAIL abort_next_count: got %0d want 2", r_n); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_next_addr[%0d]: got %0d want %0d", i, wr_q[i], exp_q[i]); end
    end
    total++; if (r_done_cnt !== 1) begin bad++; $display("FAIL abort_next_done: got %0d pulses want 1", r_done_cnt); end
  endtask

  task automatic test_busy_ignore;
    int dbad;
    send_cmd(8'd0, 8'd0, 8'd2, 8'd1, 12'h111);
    // A second command held valid the whole time the block is busy.
    cmd_x = 8'd50; cmd_y = 8'd50; cmd_w = 8'd5; cmd_h = 8'd5; cmd_color = 12'h222;
    cmd_valid = 1'b1;
    collect(100, 0);
    cmd_valid = 1'b0;
    exp_q = '{15'd0, 15'd1};
    total++; if (r_n !== 2) begin bad++; $display("FAIL ignore_count: got %0d want 2", r_n); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL ignore_addr[%0d]: got %0d want %0d", i, wr_q[i], exp_q[i]); end
    end
    dbad = 0;
    foreach (dat_q[i]) if (dat_q[i] !== 12'h111) dbad++;
    total++; if (dbad !== 0) begin bad++; $display("FAIL ignore_data: got %0d wrong words want 0", dbad); end
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_abort_accept;
    abort = 1'b1;
    send_cmd(8'd5, 8'd0, 8'd1, 8'd1, 12'h3C3);
    abort = 1'b0;
    collect(100, 0);
    total++; if (r_n !== 1) begin bad++; $display("FAIL abacc_count: got %0d want 1", r_n); end
    total++; if (wr_q.size() > 0 && wr_q[0] !== 15'd5) begin bad++; $display("FAIL abacc_addr: got %0d want 5", wr_q[0]); end
    total++; if (r_first !== 2) begin bad++; $display("FAIL abacc_first: got cycle %0d want 2", r_first); end
    total++; if (r_done_cnt !== 1) begin bad++; $display("FAIL abacc_done: got %0d pulses want 1", r_done_cnt); end
  endtask

  task automatic test_reset_mid_fill;
    int late_wr;
    send_cmd(8'd0, 8'd2, 8'd8, 8'd2, 12'h777);
    repeat (4) @(negedge clock);
    total++; if (fb_wren !== 1'b1) begin bad++; $display("FAIL rst_pre_wren: got %b want 1", fb_wren); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (fb_wren !== 1'b0) begin bad++; $display("FAIL rst_async_wren: got %b want 0", fb_wren); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    total++; if (fb_address !== 15'd0) begin bad++; $display("FAIL rst_async_addr: got %0d want 0", fb_address); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    late_wr = 0;
    repeat (4) begin
      @(negedge clock);
      if (fb_wren) late_wr++;
    end
    total++; if (late_wr !== 0) begin bad++; $display("FAIL rst_no_resume: got %0d writes want 0", late_wr); end
    send_cmd(8'd7, 8'd0, 8'd1, 8'd1, 12'h0AA);
    collect(100, 0);
    total++; if (r_n !== 1 || (wr_q.size() > 0 && wr_q[0] !== 15'd7)) begin bad++; $display("FAIL rst_next_cmd: got %0d writes want 1 at 7", r_n); end
    total++; if (r_done_cnt !== 1) begin bad++; $display("FAIL rst_next_done: got %0d pulses want 1", r_done_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_basic;
    test_clip;
    test_empty;
    test_abort;
    test_busy_ignore;
    test_abort_accept;
    test_reset_mid_fill;
    test_full;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
